// File: rtl/reg_file_sp.sv
// reg_file_sp: four-entry register file (R3 = SP) with D/E operand registers.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write-back to reads.
module reg_file_sp #(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  SP_RESET = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sd1,
    input  logic              sd2,
    input  logic              sd3,
    input  logic [1:0]        ra_addr,
    input  logic [1:0]        rb_addr,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc_plus1,
    input  logic [1:0]        sp_op,
    input  logic              stall,
    input  logic              wb_en,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [1:0]        wr_addr_q,
    output logic [DATA_W-1:0] sp_addr,
    output logic              stack_err
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic [1:0]        wr_addr_d;
    logic [DATA_W-1:0] sp_addr_q, sp_addr_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] sp;
    logic              sp_push, sp_pop, sp_eff, wb_drop;
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] val_a, val_b;

    // Operand selection, SP arithmetic and register-array next state
    always_comb begin
        sp      = regs_q[3];
        sp_push = (sp_op == 2'b01);
        sp_pop  = (sp_op == 2'b10);
        sp_eff  = !stall && (sp_push || sp_pop);
        // SP update owns R3 this cycle; the write-back is lost
        wb_drop = wb_en && (wb_addr == 2'd3) && sp_eff;

`ifdef REGFILE_BYPASS_EN
        byp_a = wb_en && !wb_drop && (wb_addr == ra_addr);
        byp_b = wb_en && !wb_drop && (wb_addr == rb_addr);
`else
        byp_a = 1'b0;
        byp_b = 1'b0;
`endif

        val_a = byp_a ? wb_data : regs_q[ra_addr];
        val_b = byp_b ? wb_data : regs_q[rb_addr];

        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        wr_addr_d = wr_addr_q;
        sp_addr_d = sp_addr_q;
        if (!stall) begin
            rd_a_d    = sd2 ? val_a : imm;
            rd_b_d    = sd3 ? pc_plus1 : val_b;
            wr_addr_d = sd1 ? 2'd3 : ra_addr;
            sp_addr_d = sp_pop ? sp + ONE : sp;
        end

        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_en && !wb_drop) begin
            regs_d[wb_addr] = wb_data;
        end
        if (sp_eff) begin
            regs_d[3] = sp_push ? sp - ONE : sp + ONE;
        end

        err_d = err_q;
        if (sp_eff && sp_push && (sp == '0)) begin
            err_d = 1'b1;
        end
        if (sp_eff && sp_pop && (sp == '1)) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous reset to the empty-stack state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q[0] <= '0;
            regs_q[1] <= '0;
            regs_q[2] <= '0;
            regs_q[3] <= SP_RESET;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_addr_q <= 2'd0;
            sp_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wr_addr_q <= wr_addr_d;
            sp_addr_q <= sp_addr_d;
            err_q     <= err_d;
        end
    end

    assign rd_a      = rd_a_q;
    assign rd_b      = rd_b_q;
    assign sp_addr   = sp_addr_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_reg_file_sp.sv
// tb_reg_file_sp: directed and random stimulus against a behavioural
// register-file/stack model, checked on every negative clock edge.
module tb_reg_file_sp;

    logic       clk;
    logic       rst_n;
    logic       sd1, sd2, sd3;
    logic [1:0] ra_addr, rb_addr;
    logic [7:0] imm, pc_plus1;
    logic [1:0] sp_op;
    logic       stall;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [7:0] rd_a, rd_b;
    logic [1:0] wr_addr_q;
    logic [7:0] sp_addr;
    logic       stack_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    // behavioural model state
    logic [7:0] m_regs [4];
    logic [7:0] e_a, e_b, e_spa;
    logic [1:0] e_wr;
    logic       e_err;

    reg_file_sp dut (
        .clk(clk), .rst_n(rst_n),
        .sd1(sd1), .sd2(sd2), .sd3(sd3),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .imm(imm), .pc_plus1(pc_plus1),
        .sp_op(sp_op), .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_a(rd_a), .rd_b(rd_b), .wr_addr_q(wr_addr_q),
        .sp_addr(sp_addr), .stack_err(stack_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("rd_a", rd_a, e_a);
            chk("rd_b", rd_b, e_b);
            chk("wr_addr", wr_addr_q, e_wr);
            chk("sp_addr", sp_addr, e_spa);
            chk("stack_err", stack_err, e_err);
        end
    end

    task automatic model_reset();
        m_regs[0] = 0; m_regs[1] = 0; m_regs[2] = 0; m_regs[3] = 8'hFF;
        e_a = 0; e_b = 0; e_wr = 0; e_spa = 0; e_err = 0;
    endtask

    // drive one instruction, advance one edge, then commit the model
    task automatic step(input bit s1, input bit s2, input bit s3,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic [7:0] im, input logic [7:0] pc,
                        input logic [1:0] op, input bit st,
                        input bit we, input logic [1:0] wa,
                        input logic [7:0] wd);
        logic [7:0] n [4];
        logic [7:0] sp, va, vb, na, nb, nspa;
        logic [1:0] nwr;
        logic       nerr;
        bit         eff, drop, bypass;
        sd1 = s1; sd2 = s2; sd3 = s3; ra_addr = ra; rb_addr = rb;
        imm = im; pc_plus1 = pc; sp_op = op; stall = st;
        wb_en = we; wb_addr = wa; wb_data = wd;
`ifdef REGFILE_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
        sp   = m_regs[3];
        eff  = !st && (op == 2'd1 || op == 2'd2);
        drop = we && wa == 2'd3 && eff;
        va = (bypass && we && !drop && wa == ra) ? wd : m_regs[ra];
        vb = (bypass && we && !drop && wa == rb) ? wd : m_regs[rb];
        na = e_a; nb = e_b; nwr = e_wr; nspa = e_spa; nerr = e_err;
        if (!st) begin
            na   = s2 ? va : im;
            nb   = s3 ? pc : vb;
            nwr  = s1 ? 2'd3 : ra;
            nspa = (op == 2'd2) ? 8'(sp + 1) : sp;
        end
        n = m_regs;
        if (we && !drop) n[wa] = wd;
        if (eff && op == 2'd1) begin
            if (sp == 8'h00) nerr = 1;
            n[3] = 8'(sp - 1);
        end
        if (eff && op == 2'd2) begin
            if (sp == 8'hFF) nerr = 1;
            n[3] = 8'(sp + 1);
        end
        @(posedge clk);
        #1;
        m_regs = n;
        e_a = na; e_b = nb; e_wr = nwr; e_spa = nspa; e_err = nerr;
    endtask

    task automatic idle(input logic [1:0] op);
        step(0, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, op, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic read_sp();
        step(0, 1, 0, 2'd3, 2'd0, 8'h00, 8'h00, 2'd0, 0, 0, 2'd0, 8'h00);
    endtask

    // asynchronous reset pulse landing between clock edges
    task automatic pulse_reset();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_rd_a", rd_a, 8'h00);
        chk("rst_rd_b", rd_b, 8'h00);
        chk("rst_wr", wr_addr_q, 2'd0);
        chk("rst_sp_addr", sp_addr, 8'h00);
        chk("rst_err", stack_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [7:0] old_r1;
        rst_n = 0;
        sd1 = 0; sd2 = 0; sd3 = 0; ra_addr = 0; rb_addr = 0;
        imm = 0; pc_plus1 = 0; sp_op = 0; stall = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        model_reset();
        #12;
        chk("reset_rd_a", rd_a, 8'h00);
        chk("reset_rd_b", rd_b, 8'h00);
        chk("reset_sp_addr", sp_addr, 8'h00);
        chk("reset_err", stack_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cmp_en = 1;

        // first push after reset
        idle(2'd1);
        chk("push_sp_addr", sp_addr, 8'hFF);
        read_sp();
        chk("sp_after_push", rd_a, 8'hFE);

        // two pushes, two pops from a fresh stack
        pulse_reset();
        idle(2'd1); chk("pp0", sp_addr, 8'hFF);
        idle(2'd1); chk("pp1", sp_addr, 8'hFE);
        idle(2'd2); chk("pp2", sp_addr, 8'hFE);
        idle(2'd2); chk("pp3", sp_addr, 8'hFF);
        read_sp();  chk("pp_sp", rd_a, 8'hFF);

        // CALL
        step(1, 0, 1, 2'd0, 2'd0, 8'h00, 8'h42, 2'd1, 0, 0, 2'd0, 8'h00);
        chk("call_rd_b", rd_b, 8'h42);
        chk("call_wr", wr_addr_q, 2'd3);
        chk("call_sp_addr", sp_addr, 8'hFF);

        // write-back vs same-cycle read
        step(0, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0, 0, 1, 2'd1, 8'h33);
        old_r1 = 8'h33;
        step(0, 1, 0, 2'd1, 2'd0, 8'h00, 8'h00, 2'd0, 0, 1, 2'd1, 8'h5A);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd_a", rd_a, 8'h5A);
`else
        chk("nobypass_rd_a", rd_a, old_r1);
`endif

        // push from SP = 00 wraps and sets the sticky flag
        pulse_reset();
        step(0, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0, 0, 1, 2'd3, 8'h00);
        idle(2'd1);
        chk("wrap_sp_addr", sp_addr, 8'h00);
        chk("wrap_err", stack_err, 1'b1);
        read_sp();
        chk("wrap_sp", rd_a, 8'hFF);
        chk("wrap_err_sticky", stack_err, 1'b1);

        // SP update beats a same-cycle write-back to R3
        step(0, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0, 0, 1, 2'd3, 8'h10);
        step(0, 0, 0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd2, 0, 1, 2'd3, 8'hAA);
        chk("conflict_sp_addr", sp_addr, 8'h11);
        read_sp();
        chk("conflict_sp", rd_a, 8'h11);

        // stall holds outputs and SP but commits write-back
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 2'd2, 2'd1, 8'h77, 8'h99, 2'd1, 1, 1, 2'd2, 8'h07);
            chk("stall_rd_a", rd_a, 8'h11);
            chk("stall_sp_addr", sp_addr, 8'h11);
        end
        step(0, 1, 0, 2'd3, 2'd2, 8'h00, 8'h00, 2'd1, 0, 0, 2'd0, 8'h00);
        chk("stall_wb_r2", rd_b, 8'h07);
        chk("stall_sp_kept", rd_a, 8'h11);
        chk("stall_push_addr", sp_addr, 8'h11);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                 2'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 2'($urandom), 8'($urandom));
            if (i == 200) pulse_reset();
        end

        @(negedge clk);
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
